// File: rtl/mem_pkg.sv
// Shared memory-op encodings, byte-enable constants and op classification helpers
// for the M/W pipeline stages.
package mem_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LW   = 4'd1,
      OP_LH   = 4'd2,
      OP_LHU  = 4'd3,
      OP_LB   = 4'd4,
      OP_LBU  = 4'd5,
      OP_SW   = 4'd6,
      OP_SH   = 4'd7,
      OP_SB   = 4'd8
   } mem_op_e;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   typedef struct packed {
      logic        valid;
      mem_op_e     op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] result;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] pc;
   } m_stage_t;

   typedef struct packed {
      logic        valid;
      mem_op_e     op;
      logic [1:0]  lo2;
      logic [31:0] rdata;
      logic [31:0] result;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        align_err;
   } w_stage_t;

   function automatic logic is_load(mem_op_e op);
      return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
   endfunction

   function automatic logic is_store(mem_op_e op);
      return op inside {OP_SW, OP_SH, OP_SB};
   endfunction

   function automatic logic misaligned(mem_op_e op, logic [1:0] lo2);
      case (op)
         OP_LW, OP_SW:         return lo2 != 2'b00;
         OP_LH, OP_LHU, OP_SH: return lo2[0];
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the M stage and a combinational-read data memory.
interface mem_access_unit_if;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_rdata;

   modport master (output m_data_addr, m_data_wdata, m_data_byteen, input m_data_rdata);
   modport slave  (input m_data_addr, m_data_wdata, m_data_byteen, output m_data_rdata);
endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Combinational load extension: picks the half/byte lane of the captured word
// and sign- or zero-extends it.
module load_ext
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lo2_i,
   input  mem_op_e     op_i,
   output logic [31:0] data_o
);

   logic [15:0] half;
   logic [7:0]  byte_v;

   assign half   = lo2_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   assign byte_v = rdata_i[{lo2_i, 3'b000} +: 8];

   always_comb begin
      data_o = rdata_i;
      case (op_i)
         OP_LH:   data_o = {{16{half[15]}}, half};
         OP_LHU:  data_o = {16'h0000, half};
         OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  data_o = {24'h000000, byte_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M and W pipeline registers with store byte-enable/lane replication, alignment
// check and load write-back.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               e_valid,
   input  logic [3:0]         e_mem_op,
   input  logic [31:0]        e_addr,
   input  logic [31:0]        e_wdata,
   input  logic [31:0]        e_result,
   input  logic               e_we,
   input  logic [4:0]         e_rd,
   input  logic [31:0]        e_pc,
   input  logic               m_stall,
   mem_access_unit_if.master  dbus,
   output logic [31:0]        m_inst_addr,
   output logic               m_align_err,
   output logic               w_grf_we,
   output logic [4:0]         w_grf_addr,
   output logic [31:0]        w_grf_wdata,
   output logic [31:0]        w_inst_addr
);

   m_stage_t    m_q, m_d;
   w_stage_t    w_q, w_d;
   logic        store_done_q, store_done_d;
   logic        write_ok;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] ext_data;

   always_comb begin
      m_d          = m_q;
      w_d          = w_q;
      store_done_d = store_done_q;
      if (!m_stall) begin
         m_d = '{valid: e_valid, op: mem_op_e'(e_mem_op), addr: e_addr, wdata: e_wdata,
                 result: e_result, we: e_we, rd: e_rd, pc: e_pc};
         w_d = '{valid: m_q.valid, op: m_q.op, lo2: m_q.addr[1:0], rdata: dbus.m_data_rdata,
                 result: m_q.result, we: m_q.we, rd: m_q.rd, pc: m_q.pc,
                 align_err: m_align_err};
         store_done_d = 1'b0;
      end else begin
         w_d = '0;
         // a held store has had its one write cycle once we stall past it
         if (m_q.valid && is_store(m_q.op)) store_done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_q          <= '0;
         w_q          <= '0;
         store_done_q <= 1'b0;
      end else begin
         m_q          <= m_d;
         w_q          <= w_d;
         store_done_q <= store_done_d;
      end
   end

   assign m_align_err = ALIGN_CHECK & m_q.valid & misaligned(m_q.op, m_q.addr[1:0]);
   assign write_ok    = m_q.valid & ~store_done_q & ~m_align_err;

   always_comb begin
      byteen = BE_NONE;
      wdata  = m_q.wdata;
      case (m_q.op)
         OP_SW: byteen = BE_WORD;
         OP_SH: begin
            byteen = m_q.addr[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata  = {2{m_q.wdata[15:0]}};
         end
         OP_SB: begin
            byteen = BE_BYTE0 << m_q.addr[1:0];
            wdata  = {4{m_q.wdata[7:0]}};
         end
         default: byteen = BE_NONE;
      endcase
      if (!write_ok) byteen = BE_NONE;
   end

   assign dbus.m_data_addr   = m_q.addr;
   assign dbus.m_data_wdata  = wdata;
   assign dbus.m_data_byteen = byteen;
   assign m_inst_addr        = m_q.pc;

   load_ext u_load_ext (
      .rdata_i (w_q.rdata),
      .lo2_i   (w_q.lo2),
      .op_i    (w_q.op),
      .data_o  (ext_data)
   );

   assign w_grf_we    = w_q.valid & w_q.we & (w_q.rd != 5'd0) & ~w_q.align_err;
   assign w_grf_addr  = w_q.rd;
   assign w_grf_wdata = is_load(w_q.op) ? ext_data : w_q.result;
   assign w_inst_addr = w_q.pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed cases plus random traffic against an
// instruction-level reference model with its own memory image.
module tb_mem_access_unit;
   import mem_pkg::*;

   logic        clk, reset, e_valid, e_we, m_stall;
   logic [3:0]  e_mem_op;
   logic [31:0] e_addr, e_wdata, e_result, e_pc;
   logic [4:0]  e_rd;
   logic [31:0] m_inst_addr0, w_grf_wdata0, w_inst_addr0;
   logic [31:0] m_inst_addr1, w_grf_wdata1, w_inst_addr1;
   logic        m_align_err0, w_grf_we0, m_align_err1, w_grf_we1;
   logic [4:0]  w_grf_addr0, w_grf_addr1;

   mem_access_unit_if bus0 ();
   mem_access_unit_if bus1 ();

   logic [31:0] mem     [64];
   logic [31:0] ref_mem [64];

   assign bus0.m_data_rdata = mem[bus0.m_data_addr[7:2]];
   assign bus1.m_data_rdata = mem[bus1.m_data_addr[7:2]];

   mem_access_unit #(.ALIGN_CHECK(1'b1)) dut0 (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_mem_op(e_mem_op), .e_addr(e_addr),
      .e_wdata(e_wdata), .e_result(e_result), .e_we(e_we), .e_rd(e_rd), .e_pc(e_pc),
      .m_stall(m_stall), .dbus(bus0), .m_inst_addr(m_inst_addr0), .m_align_err(m_align_err0),
      .w_grf_we(w_grf_we0), .w_grf_addr(w_grf_addr0), .w_grf_wdata(w_grf_wdata0),
      .w_inst_addr(w_inst_addr0));

   mem_access_unit #(.ALIGN_CHECK(1'b0)) dut1 (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_mem_op(e_mem_op), .e_addr(e_addr),
      .e_wdata(e_wdata), .e_result(e_result), .e_we(e_we), .e_rd(e_rd), .e_pc(e_pc),
      .m_stall(m_stall), .dbus(bus1), .m_inst_addr(m_inst_addr1), .m_align_err(m_align_err1),
      .w_grf_we(w_grf_we1), .w_grf_addr(w_grf_addr1), .w_grf_wdata(w_grf_wdata1),
      .w_inst_addr(w_inst_addr1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          valid;
      mem_op_e     op;
      logic [31:0] addr, wdata, result, pc;
      bit          we;
      logic [4:0]  rd;
   } ins_t;

   ins_t        mdl_m, mdl_w;
   bit          mdl_done, mdl_w_aerr;
   logic [31:0] mdl_w_word;
   int          n_cmp, n_bad, writes;

   function automatic bit f_mis(ins_t i);
      if (i.op == OP_LW || i.op == OP_SW) return (i.addr % 4) != 0;
      if (i.op == OP_LH || i.op == OP_LHU || i.op == OP_SH) return (i.addr % 2) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] f_be(ins_t i, bit done, bit chk);
      if (!i.valid || done || (chk && f_mis(i))) return 4'b0000;
      case (i.op)
         OP_SW:   return 4'b1111;
         OP_SH:   return 4'b0011 << (2 * i.addr[1]);
         OP_SB:   return 4'b0001 << i.addr[1:0];
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] f_wd(ins_t i);
      case (i.op)
         OP_SH:   return 32'(i.wdata[15:0]) * 32'h0001_0001;
         OP_SB:   return 32'(i.wdata[7:0]) * 32'h0101_0101;
         default: return i.wdata;
      endcase
   endfunction

   function automatic logic [31:0] f_ext(mem_op_e op, logic [31:0] word, logic [1:0] lo2);
      logic [15:0] h;
      logic [7:0]  b;
      h = 16'(word >> (16 * lo2[1]));
      b = 8'(word >> (8 * lo2));
      case (op)
         OP_LH:   return 32'($signed(h));
         OP_LHU:  return 32'(h);
         OP_LB:   return 32'($signed(b));
         OP_LBU:  return 32'(b);
         default: return word;
      endcase
   endfunction

   function automatic bit f_is_load(mem_op_e op);
      return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [3:0]  be;
      logic [31:0] wd, word;
      int          idx;
      idx  = int'(mdl_m.addr[7:2]);
      word = ref_mem[idx];
      be   = f_be(mdl_m, mdl_done, 1'b1);
      wd   = f_wd(mdl_m);
      for (int i = 0; i < 4; i++)
         if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
      if (reset) begin
         mdl_m = '{valid: 0, op: OP_NONE, addr: 0, wdata: 0, result: 0, pc: 0, we: 0, rd: 0};
         mdl_w = mdl_m;
         mdl_done = 0; mdl_w_aerr = 0; mdl_w_word = 0;
      end else if (!m_stall) begin
         mdl_w      = mdl_m;
         mdl_w_word = word;
         mdl_w_aerr = mdl_m.valid && f_mis(mdl_m);
         mdl_m = '{valid: e_valid, op: mem_op_e'(e_mem_op), addr: e_addr, wdata: e_wdata,
                   result: e_result, pc: e_pc, we: e_we, rd: e_rd};
         mdl_done = 0;
      end else begin
         mdl_w.valid = 0;
         mdl_done = 1;
      end
   endtask

   task automatic check_all();
      logic [3:0] be;
      bit         wv;
      be = f_be(mdl_m, mdl_done, 1'b1);
      chk("m_data_addr", bus0.m_data_addr, mdl_m.addr);
      chk("m_inst_addr", m_inst_addr0, mdl_m.pc);
      chk("byteen", 32'(bus0.m_data_byteen), 32'(be));
      chk("align_err", 32'(m_align_err0), 32'(mdl_m.valid && f_mis(mdl_m)));
      if (be != 0) chk("m_data_wdata", bus0.m_data_wdata, f_wd(mdl_m));
      chk("nochk_align_err", 32'(m_align_err1), 32'd0);
      chk("nochk_byteen", 32'(bus1.m_data_byteen), 32'(f_be(mdl_m, mdl_done, 1'b0)));
      wv = mdl_w.valid && mdl_w.we && (mdl_w.rd != 0);
      chk("w_grf_we", 32'(w_grf_we0), 32'(wv && !mdl_w_aerr));
      chk("nochk_w_grf_we", 32'(w_grf_we1), 32'(wv));
      if (mdl_w.valid) begin
         chk("w_grf_addr", 32'(w_grf_addr0), 32'(mdl_w.rd));
         chk("w_inst_addr", w_inst_addr0, mdl_w.pc);
         chk("w_grf_wdata", w_grf_wdata0, f_is_load(mdl_w.op) ?
             f_ext(mdl_w.op, mdl_w_word, mdl_w.addr[1:0]) : mdl_w.result);
      end
   endtask

   // one clock: model advances on the same edge as the DUT, memory writes land after it
   task automatic cyc();
      logic [3:0]  sbe;
      logic [31:0] sad, swd;
      sbe = bus0.m_data_byteen;
      sad = bus0.m_data_addr;
      swd = bus0.m_data_wdata;
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
         if (sbe[i] === 1'b1) mem[sad[7:2]][8*i +: 8] = swd[8*i +: 8];
      check_all();
   endtask

   task automatic set_e(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic we);
      e_valid = 1'b1; e_mem_op = op; e_addr = addr; e_wdata = wd; e_rd = rd; e_we = we;
      e_result = $urandom; e_pc = e_pc + 32'd4;
   endtask

   task automatic idle();
      e_valid = 1'b0; e_mem_op = OP_NONE; e_we = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"}, bus0.m_data_addr, 0);
      chk({tag, "_wdata"}, bus0.m_data_wdata, 0);
      chk({tag, "_byteen"}, 32'(bus0.m_data_byteen), 0);
      chk({tag, "_inst"}, m_inst_addr0, 0);
      chk({tag, "_aerr"}, 32'(m_align_err0), 0);
      chk({tag, "_wwe"}, 32'(w_grf_we0), 0);
      chk({tag, "_waddr"}, 32'(w_grf_addr0), 0);
      chk({tag, "_wdata_w"}, w_grf_wdata0, 0);
      chk({tag, "_winst"}, w_inst_addr0, 0);
      chk({tag, "_nochk_byteen"}, 32'(bus1.m_data_byteen), 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; writes = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mdl_m = '{valid: 0, op: OP_NONE, addr: 0, wdata: 0, result: 0, pc: 0, we: 0, rd: 0};
      mdl_w = mdl_m; mdl_done = 0; mdl_w_aerr = 0; mdl_w_word = 0;
      e_pc = 32'h0000_1000; e_addr = 0; e_wdata = 0; e_result = 0; e_rd = 0;
      idle(); m_stall = 1'b0; reset = 1'b1;
      cyc();
      chk_all_zero("reset");
      reset = 1'b0;

      // SB lane replication
      set_e(OP_SB, 32'h0000_0006, 32'h1234_56AB, 5'd1, 1'b0);
      cyc();
      chk("sb_byteen", 32'(bus0.m_data_byteen), 32'b0100);
      chk("sb_wdata", bus0.m_data_wdata, 32'hABAB_ABAB);

      // load extension from a known word
      mem[4] = 32'h8000_F0FE; ref_mem[4] = 32'h8000_F0FE;
      set_e(OP_LB, 32'h10, 0, 5'd3, 1'b1);  cyc();
      set_e(OP_LBU, 32'h10, 0, 5'd4, 1'b1); cyc();
      chk("lb_data", w_grf_wdata0, 32'hFFFF_FFFE);
      set_e(OP_LH, 32'h12, 0, 5'd5, 1'b1);  cyc();
      chk("lbu_data", w_grf_wdata0, 32'h0000_00FE);
      idle(); cyc();
      chk("lh_data", w_grf_wdata0, 32'hFFFF_8000);

      // misaligned halfword store
      set_e(OP_SH, 32'h0000_0003, 32'h5555_AAAA, 5'd7, 1'b1); cyc();
      chk("sh_mis_aerr", 32'(m_align_err0), 1);
      chk("sh_mis_byteen", 32'(bus0.m_data_byteen), 0);
      idle(); cyc();
      chk("sh_mis_wwe", 32'(w_grf_we0), 0);

      // store held by a 3-cycle stall writes exactly once
      set_e(OP_SW, 32'h20, 32'hDEAD_BEEF, 5'd9, 1'b1); cyc();
      writes = (bus0.m_data_byteen != 0) ? 1 : 0;
      idle(); m_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (bus0.m_data_byteen != 0) writes++;
         chk("stall_bubble", 32'(w_grf_we0), 0);
      end
      m_stall = 1'b0; cyc();
      chk("stall_writes", writes, 1);
      chk("stall_mem", mem[8], 32'hDEAD_BEEF);
      chk("stall_release_wwe", 32'(w_grf_we0), 1);

      // reset while a stalled store sits in M
      set_e(OP_SW, 32'h24, 32'h1111_2222, 5'd2, 1'b1); cyc();
      idle(); m_stall = 1'b1; cyc();
      reset = 1'b1; cyc();
      chk_all_zero("mid_reset");
      reset = 1'b0; m_stall = 1'b0; cyc();
      chk("post_reset_byteen", 32'(bus0.m_data_byteen), 0);

      for (int n = 0; n < 800; n++) begin
         e_valid  = ($urandom_range(0, 9) != 0);
         e_mem_op = 4'($urandom_range(0, 8));
         e_addr   = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h0, 8'($urandom)};
         e_wdata  = $urandom;
         e_result = $urandom;
         e_we     = 1'($urandom);
         e_rd     = 5'($urandom);
         e_pc     = e_pc + 32'd4;
         m_stall  = ($urandom_range(0, 3) == 0);
         reset    = ($urandom_range(0, 49) == 0);
         cyc();
      end
      reset = 1'b0; m_stall = 1'b0; idle();
      cyc(); cyc();
      for (int i = 0; i < 64; i++) chk("mem_image", mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ALIGN_CHECK, default 1, meaning: 1 enables the misalignment check, 0 masks it so m_align_err stays 0 and misaligned accesses proceed.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 e_valid  in  1  E-stage holds a real instruction.
REQ-006 e_mem_op  in  4  memory op code: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-007 e_addr  in  32  byte address computed by the ALU.
REQ-008 e_wdata  in  32  store source register value.
REQ-009 e_result  in  32  ALU result written back by non-load instructions.
REQ-010 e_we  in  1  instruction writes the GRF.
REQ-011 e_rd  in  5  destination register.
REQ-012 e_pc  in  32  instruction address.
REQ-013 m_stall  in  1  hold M stage this cycle.
REQ-014 m_data_rdata  in  32  word read combinationally at m_data_addr.
REQ-015 m_data_addr, m_data_wdata  out  32 each  memory byte address and lane-replicated store data.
REQ-016 m_data_byteen  out  4  per-byte write enable; 0 means no write.
REQ-017 m_inst_addr  out  32  PC of the M-stage instruction.
REQ-018 m_align_err  out  1  M-stage access is misaligned.
REQ-019 w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr  out  1/5/32/32  write-back port.

Function
REQ-020 M register: loads the E fields when m_stall=0; holds them when m_stall=1.
REQ-021 W register: loads from M when m_stall=0; becomes a bubble (valid=0) when m_stall=1.
REQ-022 m_data_addr=M.addr unmodified; m_inst_addr=M.pc; both driven combinationally from M.
REQ-023 SW: byteen=1111 and wdata=M.wdata.
REQ-024 SH: byteen=0011 if addr[1]=0, else 1100; wdata={h,h} with h=M.wdata[15:0].
REQ-025 SB: byteen=0001<<addr[1:0]; wdata={b,b,b,b} with b=M.wdata[7:0].
REQ-026 byteen=0 for loads, NONE, M.valid=0, or a misaligned access.
REQ-027 Misaligned means SW/LW with addr[1:0]!=0, or SH/LH/LHU with addr[0]=1; in that case m_align_err=1 (ALIGN_CHECK=1).
REQ-028 A store held by m_stall asserts byteen only in its first M cycle; a store_done flag suppresses it afterwards, and the flag clears when M advances.
REQ-029 Load capture: when M advances, W records m_data_rdata and addr[1:0].
REQ-030 LW result is the word as read.
REQ-031 LH/LHU select the half by addr[1] and sign-/zero-extend it.
REQ-032 LB/LBU select the byte by addr[1:0] and sign-/zero-extend it.
REQ-033 Non-loads write W.result.
REQ-034 w_grf_we = W.valid & W.we & (W.rd!=0) & ~W.align_err.
REQ-035 w_grf_wdata is the extended load data or W.result; w_inst_addr=W.pc.
REQ-036 Latency: an op presented in E at cycle n is in M at cycle n+1, where a store writes on the n+1→n+2 edge; its write-back is visible in cycle n+2.
REQ-037 Reset mid-stall discards the held store; no write occurs after reset.

Reset
REQ-038 On a reset edge all M/W fields, store_done and align flags SHALL be cleared, so every output reads 0 in the following cycle.
REQ-039 Reset SHALL take priority over m_stall.

Structure
REQ-040 Shared package mem_pkg SHALL hold the mem_op codes, the byteen constants, and is_load/is_store helpers.
REQ-041 Load extension SHALL be a combinational sub-module load_ext (rdata, lo2, op -> data).
REQ-042 Both pipeline registers and the byteen/wdata logic SHALL be in mem_access_unit.

Verification
REQ-043 SB addr 0x0000_0006, e_wdata 0x1234_56AB -> byteen 0100, m_data_wdata 0xABAB_ABAB.
REQ-044 With memory word 0x8000_F0FE at 0x10: LB addr 0x10 -> w_grf_wdata 0xFFFF_FFFE; LBU -> 0x0000_00FE; LH addr 0x12 -> 0xFFFF_8000.
REQ-045 SH addr 0x0000_0003 -> m_align_err=1, byteen 0000, w_grf_we 0 two cycles after issue.
REQ-046 SW addr 0x20, data 0xDEADBEEF with m_stall held high for 3 cycles -> exactly one write cycle, and W shows 3 bubbles.
REQ-047 Reset asserted while an SW is in M -> byteen 0 on the next cycle, and all outputs are 0.
